// File: rtl/acc_row_sequencer_pkg.sv
// acc_seq_pkg: shared sizes, state/phase encodings and strobe decode for the row sequencer
package acc_seq_pkg;
    localparam int NUM_ROW = 46;
    localparam int ROW_W = $clog2(NUM_ROW);
    localparam int PH_W = 4;
    localparam int SWEEP_W = 16;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROW - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPLIT = 3'd1,
        ST_COMP1 = 3'd2,
        ST_COMP2 = 3'd3,
        ST_ADD   = 3'd4,
        ST_SAVE  = 3'd5,
        ST_CAL   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        PH_SPLIT = 3'd0,
        PH_COMP1 = 3'd1,
        PH_COMP2 = 3'd2,
        PH_ADD   = 3'd3,
        PH_SAVE  = 3'd4
    } phase_e;

    typedef struct packed {
        logic step;
        logic split;
        logic comp;
        logic add_weight;
        logic save;
        logic prechargeb;
        logic cal_h;
    } strobe_t;

    function automatic phase_e phase_of(input state_e s);
        return phase_e'(3'(s - 3'd1));
    endfunction

    function automatic strobe_t decode_strobes(input state_e s);
        strobe_t r;
        r.step       = s inside {ST_SPLIT, ST_COMP1};
        r.split      = s inside {ST_SPLIT, ST_COMP1, ST_COMP2, ST_ADD, ST_SAVE};
        r.comp       = s inside {ST_COMP1, ST_COMP2};
        r.add_weight = s == ST_ADD;
        r.save       = s == ST_SAVE;
        r.prechargeb = s inside {ST_SPLIT, ST_COMP1, ST_COMP2, ST_ADD};
        r.cal_h      = s == ST_CAL;
        return r;
    endfunction
endpackage

// File: rtl/acc_row_sequencer_timer.sv
// acc_phase_timer: counts cycles within a phase, terminal count at max(len,1)-1
module acc_phase_timer
    import acc_seq_pkg::*;
(
    input  logic            clk,
    input  logic            resetb,
    input  logic            clear,
    input  logic [PH_W-1:0] len,
    output logic            tc
);
    logic [PH_W-1:0] cnt;
    logic [PH_W-1:0] last;

    assign last = (len == '0) ? '0 : len - 1'b1;
    assign tc   = cnt == last;

    // restart at every phase boundary or while parked
    always_ff @(posedge clk or negedge resetb)
        if (!resetb) cnt <= '0;
        else         cnt <= (clear || tc) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/acc_row_sequencer.sv
// acc_row_sequencer: steps the array through a row window, five timed phases per row
module acc_row_sequencer
    import acc_seq_pkg::*;
(
    input  logic               clk,
    input  logic               resetb,
    input  logic               start,
    input  logic               abort,
    input  logic               stop,
    input  logic               cal_done,
    input  logic               continuous,
    input  logic               address_enable,
    input  logic [ROW_W-1:0]   row_start,
    input  logic [ROW_W-1:0]   row_end,
    input  logic [PH_W-1:0]    len_split,
    input  logic [PH_W-1:0]    len_comp1,
    input  logic [PH_W-1:0]    len_comp2,
    input  logic [PH_W-1:0]    len_add,
    input  logic [PH_W-1:0]    len_save,
    output logic [ROW_W-1:0]   row_number,
    output logic               step,
    output logic               split,
    output logic               comp,
    output logic               add_weight,
    output logic               save,
    output logic               prechargeb,
    output logic               cal_H,
    output logic               stop_out,
    output logic               row_done,
    output logic               sweep_done,
    output logic               cfg_err,
    output logic [SWEEP_W-1:0] sweep_cnt,
    output logic [2:0]         state
);
    state_e               ps, ns;
    strobe_t              stb;
    logic [ROW_W-1:0]     row, sh_start, sh_end;
    logic [4:0][PH_W-1:0] sh_len;
    logic                 sh_cont, stop_pend, tc;
    logic                 active, win_ok, start_ok, eos, stop_now, last_row;
    logic [PH_W-1:0]      len_cur;

    assign active   = ps inside {ST_SPLIT, ST_COMP1, ST_COMP2, ST_ADD, ST_SAVE};
    assign win_ok   = (row_end >= row_start) && (row_end <= LAST_ROW);
    assign start_ok = ps == ST_IDLE && start && !abort && win_ok;
    assign eos      = ps == ST_SAVE && tc && !abort;
    assign stop_now = stop_pend || stop;
    assign last_row = row == sh_end;
    assign len_cur  = active ? sh_len[phase_of(ps)] : '0;

    assign row_done   = eos;
    assign stop_out   = eos && stop_now;
    assign sweep_done = eos && !stop_now && last_row;
    assign cfg_err    = ps == ST_IDLE && start && !abort && !win_ok;
    assign row_number = address_enable ? row : '0;
    assign state      = ps;
    assign {step, split, comp, add_weight, save, prechargeb, cal_H} = stb;

    acc_phase_timer u_timer (
        .clk    (clk),
        .resetb (resetb),
        .clear  (!active || abort),
        .len    (len_cur),
        .tc     (tc)
    );

    // next state: abort wins, phases advance on terminal count, SAVE picks the row boundary action
    always_comb begin
        ns = ps;
        if (abort)                ns = ST_IDLE;
        else if (ps == ST_IDLE)   ns = start_ok ? ST_SPLIT : ST_IDLE;
        else if (ps == ST_CAL)    ns = cal_done ? ST_IDLE : ST_CAL;
        else if (tc)              ns = ps != ST_SAVE ? state_e'(ps + 3'd1) :
                                       stop_now ? ST_CAL :
                                       (last_row && !sh_cont) ? ST_IDLE : ST_SPLIT;
    end

    // state, registered strobes, shadow config, row/sweep counters and pending stop
    always_ff @(posedge clk or negedge resetb)
        if (!resetb) begin
            ps        <= ST_IDLE;
            stb       <= '0;
            row       <= '0;
            sh_start  <= '0;
            sh_end    <= '0;
            sh_len    <= '0;
            sh_cont   <= 1'b0;
            stop_pend <= 1'b0;
            sweep_cnt <= '0;
        end else begin
            ps        <= ns;
            stb       <= decode_strobes(ns);
            stop_pend <= !abort && !eos && (stop_pend || (active && stop));
            sweep_cnt <= sweep_cnt + SWEEP_W'(sweep_done);
            row       <= ns == ST_IDLE ? '0 :
                         start_ok ? row_start :
                         (eos && ns == ST_SPLIT) ? (last_row ? sh_start : row + 1'b1) : row;
            if (start_ok) begin
                sh_start <= row_start;
                sh_end   <= row_end;
                sh_len   <= {len_save, len_add, len_comp2, len_comp1, len_split};
                sh_cont  <= continuous;
            end
        end
endmodule
